mul_digit_seq: RTL and testbench
================================

# mul_digit_seq

Sequential W×W unsigned multiplier controller that computes a full product by time-multiplexing one external 2×2 digit multiplier. It splits both operands into 2-bit digits, feeds every digit pair to the shared 2×2 core one per cycle, and accumulates the shifted 4-bit partial products. It sits between a requester using a valid/ready handshake and the combinational 2×2 array multiplier, which it sequences.

## Interface
- W, 8, operand width; even, ≥ 2. Digit count D = W/2.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  requester presents operands
- start_ready  out  1  controller can accept operands (high only in IDLE)
- a  in  W  multiplicand, sampled on accept
- b  in  W  multiplier, sampled on accept
- res_valid  out  1  product available (high only in DONE)
- res_ready  in  1  consumer takes product
- product  out  2W  registered accumulated result
- busy  out  1  state ≠ IDLE
- mul_a  out  2  digit of a driven to the 2×2 core
- mul_b  out  2  digit of b driven to the 2×2 core
- mul_p  in  4  2×2 core product, combinational in mul_a/mul_b, same cycle

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1. When start_valid=1, on the clock edge:
  - capture a→ra and b→rb;
  - clear acc;
  - set digit indices i=0, j=0;
  - go to RUN.
- RUN, one digit pair per cycle:
  - mul_a = ra[2i+1:2i], mul_b = rb[2j+1:2j];
  - acc ← acc + (mul_p << 2(i+j)), with the 4-bit mul_p zero-extended to 2W;
  - j increments; on j=D-1, j wraps to 0 and i increments;
  - after the pair (i=D-1, j=D-1) is accumulated, go to DONE.
- DONE:
  - res_valid=1 and product=acc, held stable;
  - when res_ready=1, go to IDLE on the edge.
- Outside RUN: mul_a=0 and mul_b=0.
- product always reflects acc. acc is 2W wide, and (2^W-1)² fits, so overflow is impossible.
- a and b are don't-care after capture. Changes during RUN or DONE have no effect.
- start_valid in RUN or DONE is ignored because start_ready=0. There is no queuing.
- All D² pairs are always processed. Zero operands get no early exit.

## Timing
- Reset (async, rst_n=0) values:
  - state=IDLE, acc=0, ra=rb=0, i=j=0;
  - start_ready=1, res_valid=0, busy=0, product=0, mul_a=mul_b=0.
- Reset mid-RUN or in DONE aborts immediately. The partial result is discarded, and no res_valid is produced.
- Handshake timing:
  - Accept occurs in cycle t (IDLE with start_valid=1).
  - RUN occupies cycles t+1 … t+D².
  - res_valid first goes high in cycle t+D²+1.
- Latency is D²+1 cycles from accept to res_valid. For W=8 that is 17.
- DONE→IDLE takes one edge after res_ready=1. The next accept is at the earliest in the following cycle, so there is no accept in the same cycle as result handoff.
- Back-to-back throughput, with start_valid and res_ready held high, is one product per D²+2 cycles. For W=8 that is 18.
- res_ready low in DONE stalls indefinitely. product and res_valid stay stable.

## Test plan
- W=8, a=3, b=5, res_ready=1 → mul_a/mul_b step through 16 pairs. res_valid rises 17 cycles after accept. product=15 (0x000F).
- a=255, b=255 → product=65025 (0xFE01). Observed mul_p in every RUN cycle is 9.
- a=0, b=0xA7 → still 16 RUN cycles, then product=0 and res_valid=1 for one cycle.
- a=200, b=123, res_ready low for 10 cycles in DONE → product holds 24600 (0x6018) and res_valid holds 1. start_valid pulses are ignored. IDLE follows the edge after res_ready=1.
- Accept a=77, b=91, then drive rst_n=0 in RUN cycle 7 → all outputs return to their reset values asynchronously. After release, a new op a=6, b=7 yields 42.
- start_valid and res_ready held high, operands (1,1), (2,3), (255,2) → products 1, 6, 510. Accepts are exactly 18 cycles apart.

Source files
------------

// File: rtl/mul_digit_seq.sv
// Sequential WxW unsigned multiplier that walks every 2-bit digit pair of the operands
// through one external combinational 2x2 multiplier and accumulates the shifted partials.
module mul_digit_seq #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start_valid,
   output logic           start_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [2*W-1:0] product,
   output logic           busy,
   output logic [1:0]     mul_a,
   output logic [1:0]     mul_b,
   input  logic [3:0]     mul_p
);

   localparam int D  = W / 2;
   localparam int IW = (D > 1) ? $clog2(D) : 1;
   localparam int SW = $clog2(2 * W);
   localparam logic [IW-1:0] LAST = IW'(D - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   ra_q, ra_d;
   logic [W-1:0]   rb_q, rb_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [IW-1:0]  i_q, i_d;
   logic [IW-1:0]  j_q, j_d;
   logic [1:0]     mul_a_q, mul_a_d;
   logic [1:0]     mul_b_q, mul_b_d;
   logic           start_ready_q, start_ready_d;
   logic           res_valid_q, res_valid_d;
   logic           busy_q, busy_d;
   logic [SW-1:0]  shamt_s;
   logic [2*W-1:0] pp_s;

   assign shamt_s = (SW'(i_q) + SW'(j_q)) << 1;
   assign pp_s    = (2 * W)'(mul_p);

   // Next-state logic; mul_a/mul_b are preloaded with the digits of the pair the next cycle processes
   always_comb begin
      state_d       = state_q;
      ra_d          = ra_q;
      rb_d          = rb_q;
      acc_d         = acc_q;
      i_d           = i_q;
      j_d           = j_q;
      mul_a_d       = mul_a_q;
      mul_b_d       = mul_b_q;
      start_ready_d = start_ready_q;
      res_valid_d   = res_valid_q;
      busy_d        = busy_q;
      case (state_q)
         IDLE: begin
            if (start_valid) begin
               ra_d          = a;
               rb_d          = b;
               acc_d         = '0;
               i_d           = '0;
               j_d           = '0;
               mul_a_d       = a[1:0];
               mul_b_d       = b[1:0];
               start_ready_d = 1'b0;
               busy_d        = 1'b1;
               state_d       = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            acc_d = acc_q + (pp_s << shamt_s);
            if ((i_q == LAST) && (j_q == LAST)) begin
               mul_a_d     = 2'b00;
               mul_b_d     = 2'b00;
               res_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               if (j_q == LAST) begin
                  j_d = '0;
                  i_d = i_q + IW'(1);
               end else begin
                  j_d = j_q + IW'(1);
               end
               mul_a_d = 2'(ra_q >> {i_d, 1'b0});
               mul_b_d = 2'(rb_q >> {j_d, 1'b0});
            end
         end
         DONE: begin
            if (res_ready) begin
               res_valid_d   = 1'b0;
               busy_d        = 1'b0;
               start_ready_d = 1'b1;
               state_d       = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d       = IDLE;
            mul_a_d       = 2'b00;
            mul_b_d       = 2'b00;
            res_valid_d   = 1'b0;
            busy_d        = 1'b0;
            start_ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ra_q          <= '0;
         rb_q          <= '0;
         acc_q         <= '0;
         i_q           <= '0;
         j_q           <= '0;
         mul_a_q       <= 2'b00;
         mul_b_q       <= 2'b00;
         start_ready_q <= 1'b1;
         res_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ra_q          <= ra_d;
         rb_q          <= rb_d;
         acc_q         <= acc_d;
         i_q           <= i_d;
         j_q           <= j_d;
         mul_a_q       <= mul_a_d;
         mul_b_q       <= mul_b_d;
         start_ready_q <= start_ready_d;
         res_valid_q   <= res_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign start_ready = start_ready_q;
   assign res_valid   = res_valid_q;
   assign busy        = busy_q;
   assign product     = acc_q;
   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;

endmodule

// File: tb/tb_mul_digit_seq.sv
// Directed self-checking bench for mul_digit_seq (W=8), with a behavioural 2x2 core on mul_p.
module tb_mul_digit_seq;

   logic        clk;
   logic        rst_n;
   logic        start_valid;
   logic        start_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] product;
   logic        busy;
   logic [1:0]  mul_a;
   logic [1:0]  mul_b;
   logic [3:0]  mul_p;

   int checks = 0;
   int errors = 0;

   logic [1:0] obs_a [16];
   logic [1:0] obs_b [16];
   logic [3:0] obs_p [16];

   mul_digit_seq #(.W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
      .a(a), .b(b), .res_valid(res_valid), .res_ready(res_ready), .product(product),
      .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
   );

   assign mul_p = {2'b00, mul_a} * {2'b00, mul_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one operation and walk RUN, recording the digit stream; lat = cycle of res_valid after accept, -1 on timeout
   task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, output int lat);
      int guard;
      guard = 0;
      while (!start_ready && guard < 50) begin
         tick();
         guard++;
      end
      a = op_a;
      b = op_b;
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      a = 8'h5A;
      b = 8'hC3;
      lat = 1;
      while (!res_valid && lat < 40) begin
         if (lat <= 16) begin
            obs_a[lat-1] = mul_a;
            obs_b[lat-1] = mul_b;
            obs_p[lat-1] = mul_p;
         end
         tick();
         lat++;
      end
      if (!res_valid) lat = -1;
   endtask

   task automatic test_reset();
      checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got %b expected 1", start_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", product); end
      checks++; if ({mul_a, mul_b} !== 4'h0) begin errors++; $display("FAIL reset_mul_ab: got %h expected 0", {mul_a, mul_b}); end
   endtask

   task automatic test_basic();
      int lat;
      logic [7:0] ea;
      logic [7:0] eb;
      ea = 8'd3;
      eb = 8'd5;
      res_ready = 1'b1;
      run_op(ea, eb, lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL basic_latency: got %0d expected 17", lat); end
      checks++; if (product !== 16'h000F) begin errors++; $display("FAIL basic_product: got %h expected 000f", product); end
      for (int k = 0; k < 16; k++) begin
         logic [1:0] xa;
         logic [1:0] xb;
         xa = 2'((ea >> (2 * (k / 4))) & 8'd3);
         xb = 2'((eb >> (2 * (k % 4))) & 8'd3);
         checks++;
         if (obs_a[k] !== xa || obs_b[k] !== xb) begin
            errors++;
            $display("FAIL basic_digits[%0d]: got a=%0d b=%0d expected a=%0d b=%0d", k, obs_a[k], obs_b[k], xa, xb);
         end
      end
      tick();
      checks++; if ({start_ready, busy, res_valid} !== 3'b100) begin errors++; $display("FAIL basic_back_idle: got rdy/busy/vld=%b expected 100", {start_ready, busy, res_valid}); end
      checks++; if ({mul_a, mul_b} !== 4'h0) begin errors++; $display("FAIL basic_idle_mul_ab: got %h expected 0", {mul_a, mul_b}); end
   endtask

   task automatic test_max();
      int lat;
      res_ready = 1'b1;
      run_op(8'd255, 8'd255, lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL max_latency: got %0d expected 17", lat); end
      checks++; if (product !== 16'hFE01) begin errors++; $display("FAIL max_product: got %h expected fe01", product); end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (obs_p[k] !== 4'd9) begin errors++; $display("FAIL max_mul_p[%0d]: got %0d expected 9", k, obs_p[k]); end
      end
      tick();
   endtask

   task automatic test_zero();
      int lat;
      res_ready = 1'b1;
      run_op(8'd0, 8'hA7, lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL zero_latency: got %0d expected 17", lat); end
      checks++; if (product !== 16'h0000) begin errors++; $display("FAIL zero_product: got %h expected 0000", product); end
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL zero_valid_one_cycle: got %b expected 0", res_valid); end
   endtask

   task automatic test_stall();
      int lat;
      res_ready = 1'b0;
      run_op(8'd200, 8'd123, lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL stall_latency: got %0d expected 17", lat); end
      for (int k = 0; k < 10; k++) begin
         start_valid = k[0];
         a = 8'd1;
         b = 8'd1;
         tick();
         checks++;
         if (res_valid !== 1'b1 || product !== 16'h6018 || start_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got vld=%b prod=%h rdy=%b expected 1 6018 0", k, res_valid, product, start_ready);
         end
      end
      start_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      checks++; if ({start_ready, busy, res_valid} !== 3'b100) begin errors++; $display("FAIL stall_release: got rdy/busy/vld=%b expected 100", {start_ready, busy, res_valid}); end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      res_ready = 1'b1;
      a = 8'd77;
      b = 8'd91;
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if ({start_ready, busy, res_valid} !== 3'b100) begin errors++; $display("FAIL abort_flags: got rdy/busy/vld=%b expected 100", {start_ready, busy, res_valid}); end
      checks++; if (product !== 16'h0000) begin errors++; $display("FAIL abort_product: got %h expected 0000", product); end
      checks++; if ({mul_a, mul_b} !== 4'h0) begin errors++; $display("FAIL abort_mul_ab: got %h expected 0", {mul_a, mul_b}); end
      #1;
      rst_n = 1'b1;
      tick();
      run_op(8'd6, 8'd7, lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL abort_next_latency: got %0d expected 17", lat); end
      checks++; if (product !== 16'd42) begin errors++; $display("FAIL abort_next_product: got %0d expected 42", product); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0]  ops_a [3];
      logic [7:0]  ops_b [3];
      logic [15:0] exp_p [3];
      logic [15:0] got_p [3];
      int          acc_cyc [3];
      int          nacc;
      int          nres;
      int          c;
      ops_a[0] = 8'd1;   ops_b[0] = 8'd1; exp_p[0] = 16'd1;
      ops_a[1] = 8'd2;   ops_b[1] = 8'd3; exp_p[1] = 16'd6;
      ops_a[2] = 8'd255; ops_b[2] = 8'd2; exp_p[2] = 16'd510;
      for (int k = 0; k < 3; k++) begin
         got_p[k] = 16'hDEAD;
         acc_cyc[k] = 0;
      end
      nacc = 0;
      nres = 0;
      c = 0;
      res_ready = 1'b1;
      start_valid = 1'b1;
      while (nres < 3 && c < 200) begin
         if (res_valid) begin
            got_p[nres] = product;
            nres++;
         end
         if (nacc == 3) start_valid = 1'b0;
         if (start_ready && nacc < 3) begin
            a = ops_a[nacc];
            b = ops_b[nacc];
            acc_cyc[nacc] = c;
            nacc++;
         end
         tick();
         c++;
      end
      start_valid = 1'b0;
      checks++; if (nres !== 3) begin errors++; $display("FAIL b2b_result_count: got %0d expected 3", nres); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got_p[k] !== exp_p[k]) begin errors++; $display("FAIL b2b_product[%0d]: got %0d expected %0d", k, got_p[k], exp_p[k]); end
      end
      for (int k = 1; k < 3; k++) begin
         checks++;
         if (acc_cyc[k] - acc_cyc[k-1] !== 18) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: got %0d expected 18", k, acc_cyc[k] - acc_cyc[k-1]);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start_valid = 1'b0;
      res_ready = 1'b0;
      a = 8'd0;
      b = 8'd0;
      #12;
      test_reset();
      #1;
      rst_n = 1'b1;
      tick();
      test_basic();
      test_max();
      test_zero();
      test_stall();
      test_reset_mid_run();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
